// File: rtl/seq_multiplier.sv
// Multi-cycle unsigned shift-add multiplier: one conditional add and shift per clock.
// A start/busy/done handshake is used, and the product registers hold the last result until the next one is ready.
`timescale 1ns/1ps
module seq_multiplier #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] product_lo,
  output logic [WIDTH-1:0] product_hi,
  output logic [1:0]       dbg_state
);
  // Handshake: start is accepted only in IDLE; busy covers RUN and DONE; done is a
  // single-cycle pulse in DONE, and product_hi/product_lo are valid while it is high.

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] acc_hi_q, acc_hi_d;
  logic [WIDTH-1:0] acc_lo_q, acc_lo_d;
  logic [WIDTH-1:0] prod_lo_q, prod_lo_d;
  logic [WIDTH-1:0] prod_hi_q, prod_hi_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH:0]   sum;
  logic             last_iter;

  assign last_iter = (count_q == CW'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (start) state_d = S_RUN;
      S_RUN:   if (last_iter) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy       = (state_q != S_IDLE);
    done       = (state_q == S_DONE);
    product_lo = prod_lo_q;
    product_hi = prod_hi_q;
    dbg_state  = state_q;
  end

  // The carry out of the add lands in acc_hi's MSB after the shift.
  always_comb begin
    mcand_d   = mcand_q;
    acc_hi_d  = acc_hi_q;
    acc_lo_d  = acc_lo_q;
    count_d   = count_q;
    prod_lo_d = prod_lo_q;
    prod_hi_d = prod_hi_q;
    sum       = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, mcand_q} : '0);
    case (state_q)
      S_IDLE: begin
        if (start) begin
          mcand_d  = a;
          acc_hi_d = '0;
          acc_lo_d = b;
          count_d  = '0;
        end
      end
      S_RUN: begin
        {acc_hi_d, acc_lo_d} = {sum, acc_lo_q[WIDTH-1:1]};
        count_d              = count_q + CW'(1);
        if (last_iter) begin
          prod_hi_d = sum[WIDTH:1];
          prod_lo_d = {sum[0], acc_lo_q[WIDTH-1:1]};
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mcand_q   <= '0;
      acc_hi_q  <= '0;
      acc_lo_q  <= '0;
      count_q   <= '0;
      prod_lo_q <= '0;
      prod_hi_q <= '0;
    end else begin
      mcand_q   <= mcand_d;
      acc_hi_q  <= acc_hi_d;
      acc_lo_q  <= acc_lo_d;
      count_q   <= count_d;
      prod_lo_q <= prod_lo_d;
      prod_hi_q <= prod_hi_d;
    end
  end

endmodule

// File: tb/tb_seq_multiplier.sv
// Self-checking bench for seq_multiplier at WIDTH=32 and WIDTH=8.
// Expected products come from plain a*b arithmetic. Expected timing comes from the WIDTH+1 done latency.
`timescale 1ns/1ps
module tb_seq_multiplier;

  logic        clk;
  logic        reset;

  logic        start32, busy32, done32;
  logic [31:0] a32, b32, p_lo32, p_hi32;
  logic [1:0]  st32;

  logic        start8, busy8, done8;
  logic [7:0]  a8, b8, p_lo8, p_hi8;
  logic [1:0]  st8;

  logic [63:0] exp_q[$];
  logic [15:0] exp8_q[$];

  int checks = 0;
  int errors = 0;
  int done_seen32 = 0;
  int done_seen8 = 0;

  seq_multiplier #(.WIDTH(32)) u_dut32 (
    .clk(clk), .reset(reset), .start(start32), .a(a32), .b(b32),
    .busy(busy32), .done(done32), .product_lo(p_lo32), .product_hi(p_hi32),
    .dbg_state(st32)
  );

  seq_multiplier #(.WIDTH(8)) u_dut8 (
    .clk(clk), .reset(reset), .start(start8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .product_lo(p_lo8), .product_hi(p_hi8),
    .dbg_state(st8)
  );

  // Clock and reset.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1);
  end

  always @(negedge clk) begin
    if (done32) done_seen32++;
    if (done8) done_seen8++;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s obs=0x%0h exp=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] rnd32();
    case ($urandom_range(0, 7))
      0:       return 32'h0;
      1:       return 32'hFFFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  function automatic logic [7:0] rnd8();
    case ($urandom_range(0, 7))
      0:       return 8'h0;
      1:       return 8'hFF;
      default: return 8'($urandom_range(0, 255));
    endcase
  endfunction

  // Driver: one multiply on the 32-bit instance; checks latency, busy span, hold and result.
  task automatic do_mul32(input logic [31:0] x, input logic [31:0] y);
    logic [63:0] held, exp;
    int cyc, busy_n;
    bit hold_ok;
    exp_q.push_back({32'b0, x} * {32'b0, y});
    @(negedge clk);
    held    = {p_hi32, p_lo32};
    start32 = 1'b1; a32 = x; b32 = y;
    @(negedge clk);
    start32 = 1'b0; a32 = $urandom; b32 = $urandom;
    cyc = 1; busy_n = busy32 ? 1 : 0; hold_ok = 1'b1;
    while (!done32 && cyc < 200) begin
      if ({p_hi32, p_lo32} !== held) hold_ok = 1'b0;
      @(negedge clk);
      cyc++;
      if (busy32) busy_n++;
    end
    check("lat32", 64'(cyc), 64'd33);
    check("busy32", 64'(busy_n), 64'd33);
    check("hold32", 64'(hold_ok), 64'd1);
    exp = exp_q.pop_front();
    check("prod32", {p_hi32, p_lo32}, exp);
    @(negedge clk);
    check("pulse32", {62'b0, busy32, done32}, 64'd0);
  endtask

  task automatic do_mul8(input logic [7:0] x, input logic [7:0] y);
    logic [15:0] held, exp;
    int cyc, busy_n;
    bit hold_ok;
    exp8_q.push_back({8'b0, x} * {8'b0, y});
    @(negedge clk);
    held   = {p_hi8, p_lo8};
    start8 = 1'b1; a8 = x; b8 = y;
    @(negedge clk);
    start8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom);
    cyc = 1; busy_n = busy8 ? 1 : 0; hold_ok = 1'b1;
    while (!done8 && cyc < 100) begin
      if ({p_hi8, p_lo8} !== held) hold_ok = 1'b0;
      @(negedge clk);
      cyc++;
      if (busy8) busy_n++;
    end
    check("lat8", 64'(cyc), 64'd9);
    check("busy8", 64'(busy_n), 64'd9);
    check("hold8", 64'(hold_ok), 64'd1);
    exp = exp8_q.pop_front();
    check("prod8", 64'({p_hi8, p_lo8}), 64'(exp));
    @(negedge clk);
    check("pulse8", {62'b0, busy8, done8}, 64'd0);
  endtask

  initial begin
    int base, cyc;
    reset = 1'b1;
    start32 = 1'b0; a32 = '0; b32 = '0;
    start8 = 1'b0; a8 = '0; b8 = '0;

    // Reset held two cycles, then idle with start low.
    repeat (2) @(negedge clk);
    check("rst_ctl32", {62'b0, busy32, done32}, 64'd0);
    check("rst_prod32", {p_hi32, p_lo32}, 64'd0);
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("idle_ctl32", {62'b0, busy32, done32}, 64'd0);
      check("idle_prod32", {p_hi32, p_lo32}, 64'd0);
      check("idle_ctl8", {62'b0, busy8, done8}, 64'd0);
      check("idle_prod8", 64'({p_hi8, p_lo8}), 64'd0);
    end

    do_mul32(32'd3, 32'd5);
    do_mul32(32'hFFFF_FFFF, 32'hFFFF_FFFF);

    // Starts during RUN and during DONE are ignored; zero multiplicand gives zero.
    base = done_seen32;
    exp_q.push_back(64'd0);
    @(negedge clk);
    start32 = 1'b1; a32 = 32'd0; b32 = 32'h1234_5678;
    @(negedge clk);
    start32 = 1'b0;
    repeat (5) @(negedge clk);
    start32 = 1'b1; a32 = 32'd7; b32 = 32'd9;
    @(negedge clk);
    start32 = 1'b0;
    cyc = 0;
    while (!done32 && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    check("ign_prod32", {p_hi32, p_lo32}, exp_q.pop_front());
    start32 = 1'b1; a32 = 32'd7; b32 = 32'd9;
    @(negedge clk);
    start32 = 1'b0;
    check("ign_busy32", 64'(busy32), 64'd0);
    repeat (3) @(negedge clk);
    check("ign_dones32", 64'(done_seen32 - base), 64'd1);
    do_mul32(32'd7, 32'd9);

    // Reset while iteration 10 is in progress.
    @(negedge clk);
    start32 = 1'b1; a32 = 32'h1_0000; b32 = 32'h1_0000;
    @(negedge clk);
    start32 = 1'b0;
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort_ctl32", {62'b0, busy32, done32}, 64'd0);
    check("abort_prod32", {p_hi32, p_lo32}, 64'd0);
    base = done_seen32;
    repeat (40) @(negedge clk);
    check("abort_nodone32", 64'(done_seen32 - base), 64'd0);
    do_mul32(32'd6, 32'd7);
    do_mul32(32'd1000, 32'd1000);

    for (int i = 0; i < 1000; i++) do_mul32(rnd32(), rnd32());
    for (int i = 0; i < 1000; i++) do_mul8(rnd8(), rnd8());

    check("sb_empty", 64'(exp_q.size() + exp8_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
